// File: rtl/mips_axi_rd_arbiter.sv
// mips_axi_rd_arbiter: arbitrates the instruction-fetch (m0) and data (m1) AXI read masters onto one slave read port.
// One outstanding read at a time; the grant is held from the address phase through to the R handshake.
module mips_axi_rd_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        mips_cpu_clk,
    input  logic        mips_cpu_reset,
    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      r_state;
    logic        r_grant;
    logic        r_last;
    logic [31:0] r_addr;
    logic        w_pick;
    logic        w_idle;
    logic        w_d0;
    logic        w_d1;

    // r_grant/r_last: 0 = m0, 1 = m1; contention goes to whoever did not finish last
    assign w_pick = (m0_arvalid & m1_arvalid) ? ((RR_EN != 0) ? ~r_last : 1'b1) : m1_arvalid;
    // reset masks every handshake output so nothing leaks during the reset cycle
    assign w_idle = (r_state == IDLE) & ~mips_cpu_reset;
    assign w_d0   = (r_state == DATA) & ~mips_cpu_reset & ~r_grant;
    assign w_d1   = (r_state == DATA) & ~mips_cpu_reset & r_grant;

    assign m0_arready = w_idle & m0_arvalid & ~w_pick;
    assign m1_arready = w_idle & m1_arvalid & w_pick;
    assign s_araddr   = r_addr;
    assign s_arvalid  = (r_state == ADDR) & ~mips_cpu_reset;
    assign s_rready   = (w_d0 & m0_rready) | (w_d1 & m1_rready);
    assign m0_rvalid  = w_d0 & s_rvalid;
    assign m1_rvalid  = w_d1 & s_rvalid;
    assign m0_rdata   = w_d0 ? s_rdata : '0;
    assign m1_rdata   = w_d1 ? s_rdata : '0;
    assign m0_rresp   = w_d0 ? s_rresp : '0;
    assign m1_rresp   = w_d1 ? s_rresp : '0;

    always_ff @(posedge mips_cpu_clk) begin
        if (mips_cpu_reset) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: if (m0_arvalid | m1_arvalid) begin
                    r_grant <= w_pick;
                    r_addr  <= w_pick ? m1_araddr : m0_araddr;
                    r_state <= ADDR;
                end
                ADDR: if (s_arready) r_state <= DATA;
                DATA: if (s_rvalid & s_rready) begin
                    r_state <= IDLE;
                    r_last  <= r_grant;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
